uart_rx_cfg: RTL

- Parametrised UART receiver. Successor to the fixed 8N1 receiver.
- Frame format is set at elaboration: data width, parity mode and stop-bit count.
- Adds an input synchroniser, 3-sample majority voting, false-start rejection, and parity/framing error flags.
- Sits between the board RX pin and byte-consuming logic (command decoders, FIFOs).

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_rx_sampler.sv | 53 +++++
 rtl/uart_rx_cfg.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART receiver: parity modes, FSM encoding, counter sizing.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK
  } rx_state_t;

  // Width of the intra-bit cycle counter; never narrower than one bit.
  function automatic int cnt_width(input int clks_per_bit);
    return (clks_per_bit > 1) ? $clog2(clks_per_bit) : 1;
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// RX line front end: 2-flop synchroniser plus a majority vote over samples at M-1, M and M+1.
// Latency: 2 cycles line-to-rx_sync; vote is valid combinationally while vote_stb is high.
// Backpressure: none; the line cannot be stalled, the caller owns the bit counter.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 217,
  parameter int CW           = cnt_width(CLKS_PER_BIT)
) (
  input  logic          i_Clock,
  input  logic          i_Reset,
  input  logic          i_RX_Serial,
  input  logic [CW-1:0] bit_cnt,
  output logic          rx_sync,
  output logic          rx_vote,
  output logic          vote_stb
);

  localparam int M = CLKS_PER_BIT / 2;
  localparam logic [CW-1:0] CNT_A = CW'(M - 1);
  localparam logic [CW-1:0] CNT_B = CW'(M);
  localparam logic [CW-1:0] CNT_C = CW'(M + 1);

  logic sync_q1, sync_q2;
  logic samp_a, samp_b;

  // Two-stage synchroniser; resets to the idle (high) line level.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      sync_q1 <= 1'b1;
      sync_q2 <= 1'b1;
    end else begin
      sync_q1 <= i_RX_Serial;
      sync_q2 <= sync_q1;
    end
  end

  // Capture the first two votes; the third is the live line at the decision count.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      samp_a <= 1'b1;
      samp_b <= 1'b1;
    end else begin
      if (bit_cnt == CNT_A) samp_a <= sync_q2;
      if (bit_cnt == CNT_B) samp_b <= sync_q2;
    end
  end

  assign rx_sync  = sync_q2;
  assign vote_stb = (bit_cnt == CNT_C);
  assign rx_vote  = (samp_a & samp_b) | (samp_a & sync_q2) | (samp_b & sync_q2);

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver (data width, parity, stop bits); optional break detect via UART_RX_CFG_BREAK_EN.
// Latency: o_DV one cycle after the last stop-bit decision (mid-bit), plus 2 cycles of input sync.
// Backpressure: none; o_DV is a one-cycle pulse and the consumer must accept it, outputs hold until next frame.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 217,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 i_Clock,
  input  logic                 i_Reset,
  input  logic                 i_RX_Serial,
  output logic                 o_DV,
  output logic [DATA_BITS-1:0] o_RX_Byte,
  output logic                 o_Parity_Err,
  output logic                 o_Frame_Err,
  output logic                 o_Busy,
  output logic                 o_Break
);

  localparam int CW = cnt_width(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);

  rx_state_t            state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [3:0]           bit_q, bit_d;
  logic                 stop_q, stop_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 armed_q, armed_d;
  logic                 dv_d, perr_out_d, ferr_out_d, brk_d;
  logic [DATA_BITS-1:0] byte_d;
  logic                 rx_sync, rx_vote, vote_stb;
  logic                 bit_end, par_x, ferr_now;
`ifdef UART_RX_CFG_BREAK_EN
  logic                 pbit_q, pbit_d;
`endif

  uart_rx_sampler #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .CW          (CW)
  ) u_sampler (
    .i_Clock    (i_Clock),
    .i_Reset    (i_Reset),
    .i_RX_Serial(i_RX_Serial),
    .bit_cnt    (cnt_q),
    .rx_sync    (rx_sync),
    .rx_vote    (rx_vote),
    .vote_stb   (vote_stb)
  );

  // FSM state, counters, frame accumulators and registered outputs.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      bit_q        <= '0;
      stop_q       <= 1'b0;
      shreg_q      <= '0;
      perr_q       <= 1'b0;
      ferr_q       <= 1'b0;
      armed_q      <= 1'b0;
      o_DV         <= 1'b0;
      o_RX_Byte    <= '0;
      o_Parity_Err <= 1'b0;
      o_Frame_Err  <= 1'b0;
      o_Break      <= 1'b0;
`ifdef UART_RX_CFG_BREAK_EN
      pbit_q       <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      stop_q       <= stop_d;
      shreg_q      <= shreg_d;
      perr_q       <= perr_d;
      ferr_q       <= ferr_d;
      armed_q      <= armed_d;
      o_DV         <= dv_d;
      o_RX_Byte    <= byte_d;
      o_Parity_Err <= perr_out_d;
      o_Frame_Err  <= ferr_out_d;
      o_Break      <= brk_d;
`ifdef UART_RX_CFG_BREAK_EN
      pbit_q       <= pbit_d;
`endif
    end
  end

  // Next-state and next-output logic; each state advances on the vote strobe or the bit boundary.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    stop_d     = stop_q;
    shreg_d    = shreg_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    armed_d    = armed_q;
    dv_d       = 1'b0;
    byte_d     = o_RX_Byte;
    perr_out_d = o_Parity_Err;
    ferr_out_d = o_Frame_Err;
    brk_d      = 1'b0;
`ifdef UART_RX_CFG_BREAK_EN
    pbit_d     = pbit_q;
`endif
    bit_end    = (cnt_q == LAST_CNT);
    par_x      = (^shreg_q) ^ rx_vote;
    ferr_now   = ferr_q | ~rx_vote;

    if (state_q != ST_IDLE) cnt_d = bit_end ? '0 : cnt_q + CW'(1);

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        // A low line only starts a frame once the line has been seen high.
        if (rx_sync) begin
          armed_d = 1'b1;
        end else if (armed_q) begin
          state_d = ST_START;
          armed_d = 1'b0;
          bit_d   = '0;
          stop_d  = 1'b0;
          perr_d  = 1'b0;
          ferr_d  = 1'b0;
`ifdef UART_RX_CFG_BREAK_EN
          pbit_d  = 1'b0;
`endif
        end
      end
      ST_START: begin
        if (vote_stb && rx_vote) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          armed_d = 1'b1;
        end else if (bit_end) begin
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (vote_stb) shreg_d = {rx_vote, shreg_q[DATA_BITS-1:1]};
        if (bit_end) begin
          if (bit_q == 4'(DATA_BITS - 1)) state_d = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
          else                            bit_d   = bit_q + 4'd1;
        end
      end
      ST_PARITY: begin
        if (vote_stb) begin
          perr_d = (PARITY == PARITY_ODD) ? ~par_x : par_x;
`ifdef UART_RX_CFG_BREAK_EN
          pbit_d = rx_vote;
`endif
        end
        if (bit_end) state_d = ST_STOP;
      end
      ST_STOP: begin
        if (vote_stb) begin
`ifdef UART_RX_CFG_BREAK_EN
          if (!stop_q && !rx_vote && (shreg_q == '0) && !pbit_q) begin
            state_d    = ST_BREAK;
            cnt_d      = '0;
            dv_d       = 1'b1;
            byte_d     = shreg_q;
            perr_out_d = perr_q;
            ferr_out_d = 1'b1;
            brk_d      = 1'b1;
          end else
`endif
          if (stop_q == 1'(STOP_BITS - 1)) begin
            // Leave at the decision so a new start edge is caught straight away.
            state_d    = ST_IDLE;
            cnt_d      = '0;
            armed_d    = rx_vote;
            dv_d       = 1'b1;
            byte_d     = shreg_q;
            perr_out_d = perr_q;
            ferr_out_d = ferr_now;
          end else begin
            ferr_d = ferr_now;
          end
        end else if (bit_end) begin
          stop_d = 1'b1;
        end
      end
`ifdef UART_RX_CFG_BREAK_EN
      ST_BREAK: begin
        // Wait for one full bit time of continuous high line before re-arming.
        cnt_d = (rx_sync && !bit_end) ? cnt_q + CW'(1) : '0;
        if (rx_sync && bit_end) begin
          state_d = ST_IDLE;
          armed_d = 1'b1;
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign o_Busy = (state_q != ST_IDLE);

endmodule
